mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arbiter_fill_counter.sv | 52 +++++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, requester
// identities, block geometry and the block-base helper.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_IFILL,
        ST_DFILL,
        ST_DONE
    } arb_state_t;

    // Which requester a fill belongs to, or which one was just served.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WRITE,
        SRC_DMISS,
        SRC_IMISS
    } arb_src_t;

    localparam int unsigned BLOCK_WORDS_DEFAULT = 8;
    localparam int unsigned MEM_LAT_DEFAULT     = 4;
    localparam int unsigned WORD_IDX_W          = 3;
    localparam logic [15:0] BLOCK_OFFSET_MASK   = 16'h000F;

    // Byte address of the first word of the 16-byte block holding addr.
    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & ~BLOCK_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Issue and return word counters for one block fill. Both saturate at the
// last word so a fill never wraps; the issue side raises issue_done once the
// last read has gone out.
module fill_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  issue_en,
    input  logic                  ret_en,
    output logic [WORD_IDX_W-1:0] issue_cnt,
    output logic                  issue_done,
    output logic [WORD_IDX_W-1:0] ret_cnt,
    output logic                  ret_last
);

    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(BLOCK_WORDS - 1);

    assign ret_last = (ret_cnt == LAST_IDX);

    // Issue counter: one read per cycle, holds at the last word, then flags done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt  <= '0;
            issue_done <= 1'b0;
        end else if (clr) begin
            issue_cnt  <= '0;
            issue_done <= 1'b0;
        end else if (issue_en && !issue_done) begin
            if (issue_cnt == LAST_IDX) begin
                issue_done <= 1'b1;
            end else begin
                issue_cnt <= issue_cnt + 1'b1;
            end
        end
    end

    // Return counter: advances on each returned word, holds at the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_cnt <= '0;
        end else if (clr) begin
            ret_cnt <= '0;
        end else if (ret_en && !ret_last) begin
            ret_cnt <= ret_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the shared data-memory port. Serves D-cache write-through
// words, D-cache block fills and I-cache block fills, one transaction at a
// time, with priority write > D-miss > I-miss decided only in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT     = MEM_LAT_DEFAULT,
    parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imiss_req,
    input  logic [15:0] imiss_addr,
    input  logic        dmiss_req,
    input  logic [15:0] dmiss_addr,
    input  logic        dwrite_req,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        ifill_we,
    output logic        dfill_we,
    output logic        idone,
    output logic        ddone,
    output logic        dwrite_done
);

    // The 3-bit word index and 16-byte block mask only describe 8-word blocks,
    // and a zero-latency memory cannot return in the cycle after issue.
    if (BLOCK_WORDS != 8 || MEM_LAT < 1) begin : g_param_check
        $error("mem_arbiter: BLOCK_WORDS must be 8 and MEM_LAT at least 1");
    end

    arb_state_t            state;
    arb_state_t            state_nxt;
    arb_src_t              fill_src;
    arb_src_t              done_src;
    logic [15:0]           base;
    logic                  in_fill;
    logic                  grant_write;
    logic                  grant_dmiss;
    logic                  grant_imiss;
    logic [WORD_IDX_W-1:0] issue_cnt;
    logic [WORD_IDX_W-1:0] ret_cnt;
    logic                  issue_done;
    logic                  ret_last;

    assign in_fill = (state == ST_IFILL) || (state == ST_DFILL);

    fill_counter #(
        .BLOCK_WORDS(BLOCK_WORDS)
    ) u_fill_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state == ST_IDLE),
        .issue_en  (in_fill),
        .ret_en    (in_fill && mem_data_valid),
        .issue_cnt (issue_cnt),
        .issue_done(issue_done),
        .ret_cnt   (ret_cnt),
        .ret_last  (ret_last)
    );

    // Priority grant in IDLE; the requester served last is masked for one
    // cycle because its request is still high while it reacts to the done pulse
    always_comb begin
        grant_write = 1'b0;
        grant_dmiss = 1'b0;
        grant_imiss = 1'b0;
        if (state == ST_IDLE) begin
            if (dwrite_req && (done_src != SRC_WRITE)) begin
                grant_write = 1'b1;
            end else if (dmiss_req && (done_src != SRC_DMISS)) begin
                grant_dmiss = 1'b1;
            end else if (imiss_req && (done_src != SRC_IMISS)) begin
                grant_imiss = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch block base and owner on a fill grant; remember who was just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            fill_src <= SRC_NONE;
            done_src <= SRC_NONE;
        end else begin
            if (grant_dmiss) begin
                base     <= block_base(dmiss_addr);
                fill_src <= SRC_DMISS;
            end else if (grant_imiss) begin
                base     <= block_base(imiss_addr);
                fill_src <= SRC_IMISS;
            end
            case (state)
                ST_WRITE: done_src <= SRC_WRITE;
                ST_DONE:  done_src <= fill_src;
                default:  done_src <= SRC_NONE;
            endcase
        end
    end

    // Next state and all memory / cache-side outputs from state and counters
    always_comb begin
        state_nxt   = state;
        mem_addr    = '0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_data_in = '0;
        fill_data   = '0;
        fill_word   = '0;
        ifill_we    = 1'b0;
        dfill_we    = 1'b0;
        idone       = 1'b0;
        ddone       = 1'b0;
        dwrite_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_write) begin
                    state_nxt = ST_WRITE;
                end else if (grant_dmiss) begin
                    state_nxt = ST_DFILL;
                end else if (grant_imiss) begin
                    state_nxt = ST_IFILL;
                end
            end
            ST_WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = dwrite_addr;
                mem_data_in = dwrite_data;
                dwrite_done = 1'b1;
                state_nxt   = ST_IDLE;
            end
            ST_IFILL, ST_DFILL: begin
                if (!issue_done) begin
                    mem_enable = 1'b1;
                    mem_addr   = base + 16'({issue_cnt, 1'b0});
                end
                fill_word = ret_cnt;
                if (mem_data_valid) begin
                    fill_data = mem_data_out;
                    ifill_we  = (state == ST_IFILL);
                    dfill_we  = (state == ST_DFILL);
                    if (ret_last) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                idone     = (fill_src == SRC_IMISS);
                ddone     = (fill_src == SRC_DMISS);
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latency-MEM_LAT memory model, a
// scoreboard of expected fill words, a table of single-grant vectors and
// hand-written multi-cycle sequences.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imiss_req;
    logic [15:0] imiss_addr;
    logic        dmiss_req;
    logic [15:0] dmiss_addr;
    logic        dwrite_req;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        ifill_we;
    logic        dfill_we;
    logic        idone;
    logic        ddone;
    logic        dwrite_done;
    logic        stray_vld;

    mem_arbiter #(
        .MEM_LAT    (LAT),
        .BLOCK_WORDS(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imiss_req     (imiss_req),
        .imiss_addr    (imiss_addr),
        .dmiss_req     (dmiss_req),
        .dmiss_addr    (dmiss_addr),
        .dwrite_req    (dwrite_req),
        .dwrite_addr   (dwrite_addr),
        .dwrite_data   (dwrite_data),
        .mem_addr      (mem_addr),
        .mem_enable    (mem_enable),
        .mem_wr        (mem_wr),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out),
        .mem_data_valid(mem_data_valid),
        .fill_data     (fill_data),
        .fill_word     (fill_word),
        .ifill_we      (ifill_we),
        .dfill_we      (dfill_we),
        .idone         (idone),
        .ddone         (ddone),
        .dwrite_done   (dwrite_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory: a read accepted at an edge returns LAT cycles later.
    logic [LAT-1:0] pv = '0;
    logic [15:0]    pa [LAT];

    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], mem_enable & ~mem_wr};
        pa[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end

    assign mem_data_valid = pv[LAT-1] | stray_vld;
    assign mem_data_out   = pv[LAT-1] ? mdata(pa[LAT-1]) : 16'hDEAD;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {mem_addr, mem_data_in, fill_data, 5'(fill_word), mem_enable, mem_wr,
                   ifill_we, dfill_we, idone, ddone, dwrite_done}, 64'h0);
    endtask

    // Scoreboard of fill words expected at the cache-side write port.
    typedef struct packed {
        logic        side_d;
        logic [2:0]  word;
        logic [15:0] data;
    } fill_exp_t;

    fill_exp_t sb_q[$];
    fill_exp_t mon_e;

    task automatic push_fill(input logic side_d, input logic [15:0] addr);
        logic [15:0] b;
        b = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back('{side_d: side_d, word: 3'(k), data: mdata(b + 16'(2 * k))});
        end
    endtask

    always @(negedge clk) begin
        if (ifill_we || dfill_we) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fill: ifill_we=%0b dfill_we=%0b word=%0d, want no fill write",
                         ifill_we, dfill_we, fill_word);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_dfill_we", 64'(dfill_we), 64'(mon_e.side_d));
                chk("sb_ifill_we", 64'(ifill_we), 64'(!mon_e.side_d));
                chk("sb_fill_word", 64'(fill_word), 64'(mon_e.word));
                chk("sb_fill_data", 64'(fill_data), 64'(mon_e.data));
            end
        end
    end

    // Waits (bounded) for a done pulse and checks which side it belongs to.
    task automatic wait_done(input string name, input bit want_d, input int limit, output int seen);
        seen = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (idone || ddone) begin
                seen = cyc;
                break;
            end
        end
        checks++;
        if (seen < 0) begin
            failures++;
            $display("FAIL %s_timeout: no done pulse in %0d cycles, want %s", name, limit,
                     want_d ? "ddone" : "idone");
        end else if (ddone !== want_d || idone !== !want_d) begin
            failures++;
            $display("FAIL %s_side: idone=%0b ddone=%0b, want ddone=%0b", name, idone, ddone, want_d);
        end
    endtask

    typedef struct {
        logic        imiss;
        logic        dmiss;
        logic        dwrite;
        logic [15:0] iaddr;
        logic [15:0] daddr;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        wdone;
        int          kind;   // 0 none, 1 write, 2 D fill, 3 I fill
    } vec_t;

    vec_t vt[8];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int t0;
        int dc;
        int dc2;

        rst_n       = 1'b0;
        imiss_req   = 1'b0;
        imiss_addr  = '0;
        dmiss_req   = 1'b0;
        dmiss_addr  = '0;
        dwrite_req  = 1'b0;
        dwrite_addr = '0;
        dwrite_data = '0;
        stray_vld   = 1'b0;

        vt[0] = '{0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
        vt[1] = '{1, 0, 0, 16'h1236, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h1230, 16'h0000, 0, 3};
        vt[2] = '{0, 1, 0, 16'h0000, 16'hABCF, 16'h0000, 16'h0000, 1, 0, 16'hABC0, 16'h0000, 0, 2};
        vt[3] = '{1, 1, 0, 16'h0F0A, 16'h4444, 16'h0000, 16'h0000, 1, 0, 16'h4440, 16'h0000, 0, 2};
        vt[4] = '{1, 1, 1, 16'h1000, 16'h2000, 16'h0040, 16'hBEEF, 1, 1, 16'h0040, 16'hBEEF, 1, 1};
        vt[5] = '{0, 0, 1, 16'h0000, 16'h0000, 16'hFFFE, 16'h1234, 1, 1, 16'hFFFE, 16'h1234, 1, 1};
        vt[6] = '{0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 16'hFFF0, 16'h0000, 0, 2};
        vt[7] = '{1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset_outputs");
        #1 rst_n = 1'b1;
        step();
        step();

        // I-miss at 0x1236: cycle-exact issue, return and done timing
        imiss_addr = 16'h1236;
        imiss_req  = 1'b1;
        push_fill(1'b0, 16'h1236);
        for (int c = 1; c <= 13; c++) begin
            step();
            @(negedge clk);
            chk($sformatf("A_en_c%0d", c), 64'(mem_enable), 64'(c <= 8));
            chk($sformatf("A_wr_c%0d", c), 64'(mem_wr), 64'h0);
            if (c <= 8) chk($sformatf("A_addr_c%0d", c), 64'(mem_addr), 64'(16'h1230 + 16'(2 * (c - 1))));
            chk($sformatf("A_ifill_we_c%0d", c), 64'(ifill_we), 64'(c >= 5 && c <= 12));
            chk($sformatf("A_idone_c%0d", c), 64'(idone), 64'(c == 13));
        end
        step();
        @(negedge clk);
        chk("A_no_regrant", 64'(mem_enable), 64'h0);
        step();
        imiss_req = 1'b0;
        @(negedge clk);
        chk_quiet("A_idle_after");

        // Single-grant vectors: priority and first-cycle memory port values
        for (int v = 0; v < 8; v++) begin
            step();
            imiss_req   = vt[v].imiss;
            imiss_addr  = vt[v].iaddr;
            dmiss_req   = vt[v].dmiss;
            dmiss_addr  = vt[v].daddr;
            dwrite_req  = vt[v].dwrite;
            dwrite_addr = vt[v].waddr;
            dwrite_data = vt[v].wdata;
            t0 = cyc;
            if (vt[v].kind == 2) push_fill(1'b1, vt[v].daddr);
            if (vt[v].kind == 3) push_fill(1'b0, vt[v].iaddr);
            step();
            @(negedge clk);
            chk($sformatf("V%0d_en", v), 64'(mem_enable), 64'(vt[v].en));
            chk($sformatf("V%0d_wr", v), 64'(mem_wr), 64'(vt[v].wr));
            chk($sformatf("V%0d_addr", v), 64'(mem_addr), 64'(vt[v].addr));
            chk($sformatf("V%0d_din", v), 64'(mem_data_in), 64'(vt[v].din));
            chk($sformatf("V%0d_wdone", v), 64'(dwrite_done), 64'(vt[v].wdone));
            step();
            dwrite_req = 1'b0;
            if (vt[v].kind <= 1) begin
                imiss_req = 1'b0;
                dmiss_req = 1'b0;
            end else begin
                if (vt[v].kind == 2) imiss_req = 1'b0;
                else dmiss_req = 1'b0;
                wait_done($sformatf("V%0d_done", v), vt[v].kind == 2, 30, dc);
                chk($sformatf("V%0d_done_cycle", v), 64'(dc - t0), 64'd13);
                step();
                step();
                imiss_req = 1'b0;
                dmiss_req = 1'b0;
            end
            step();
            @(negedge clk);
            chk_quiet($sformatf("V%0d_idle_after", v));
        end

        // Simultaneous D- and I-miss: D first, I granted right after ddone
        step();
        dmiss_addr = 16'h2000;
        imiss_addr = 16'h3008;
        dmiss_req  = 1'b1;
        imiss_req  = 1'b1;
        push_fill(1'b1, 16'h2000);
        push_fill(1'b0, 16'h3008);
        wait_done("B_ddone", 1'b1, 30, dc);
        step();
        step();
        dmiss_req = 1'b0;
        wait_done("B_idone", 1'b0, 30, dc2);
        chk("B_idone_gap", 64'(dc2 - dc), 64'd14);
        step();
        step();
        imiss_req = 1'b0;

        // Write beside a D-miss: write in cycle 1, fill starts cycle 3
        step();
        dwrite_addr = 16'h0040;
        dwrite_data = 16'hBEEF;
        dwrite_req  = 1'b1;
        dmiss_addr  = 16'h0100;
        dmiss_req   = 1'b1;
        push_fill(1'b1, 16'h0100);
        step();
        @(negedge clk);
        chk("C_c1_port", {mem_addr, mem_data_in, 29'h0, mem_enable, mem_wr, dwrite_done},
            {16'h0040, 16'hBEEF, 29'h0, 3'b111});
        step();
        @(negedge clk);
        chk("C_c2_quiet", {62'h0, mem_enable, dwrite_done}, 64'h0);
        step();
        dwrite_req = 1'b0;
        @(negedge clk);
        chk("C_c3_fill", {mem_addr, 46'h0, mem_enable, mem_wr}, {16'h0100, 46'h0, 2'b10});
        wait_done("C_ddone", 1'b1, 30, dc);
        step();
        step();
        dmiss_req = 1'b0;

        // Stray mem_data_valid while IDLE
        step();
        stray_vld = 1'b1;
        @(negedge clk);
        chk("E_stray_we", {fill_data, 46'h0, ifill_we, dfill_we}, 64'h0);
        step();
        stray_vld = 1'b0;
        @(negedge clk);
        chk_quiet("E_still_idle");

        // Reset in cycle 6 of a D-fill: immediate quiet outputs, no ddone
        step();
        dmiss_addr = 16'h0500;
        dmiss_req  = 1'b1;
        sb_q.push_back('{side_d: 1'b1, word: 3'd0, data: mdata(16'h0500)});
        sb_q.push_back('{side_d: 1'b1, word: 3'd1, data: mdata(16'h0502)});
        for (int c = 1; c <= 6; c++) begin
            step();
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        dmiss_req = 1'b0;
        #1;
        chk_quiet("D_async_reset");
        @(negedge clk);
        chk_quiet("D_in_reset");
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            chk($sformatf("D_post_rst_%0d", c), {61'h0, ddone, idone, mem_enable}, 64'h0);
        end

        chk("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
